fifo_sync_flags: RTL and testbench

Single-clock, parametrised FIFO; the successor to the team's dual-pointer FIFO.
- Uses all 2**AW entries (no wasted slot).
- Adds occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow and an optional first-word-fall-through (FWFT) output.
- Sits between the CNN line buffers and the PE array, where both sides run on one clock.

---
 rtl/fifo_sync_flags.sv | 104 ++++++++++
 tb/tb_fifo_sync_flags.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO using all 2**AW entries, with occupancy count, programmable
// almost-full/almost-empty levels, sticky error flags and optional FWFT output.
module fifo_sync_flags #(
  parameter int DW     = 12,
  parameter int AW     = 9,
  parameter int FWFT   = 0,
  parameter int AF_LVL = 2**AW - 4,
  parameter int AE_LVL = 4
) (
  input  logic          clk,
  input  logic          fifo_rst_n,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   data_count,
  output logic          overflow,
  output logic          underflow,
  output logic          wr_rst_busy,
  output logic          rd_rst_busy
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          r_dout_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_mem_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_mem_rd;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (FWFT != 0) ? ~r_dout_valid : (r_count == '0);
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr_acc    = wr_en & ~w_full;
  assign w_rd_acc    = rd_en & ~w_empty;

  // In FWFT mode the output register refills whenever it is vacant or being popped.
  assign w_mem_rd = (FWFT != 0) ? ((~r_dout_valid | w_rd_acc) & ~w_mem_empty) : w_rd_acc;

  // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (FWFT != 0) r_dout_valid <= w_mem_rd | (r_dout_valid & ~w_rd_acc);
      else           r_dout_valid <= w_rd_acc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
      if (wr_en & w_full)  r_overflow  <= 1'b1;
      if (rd_en & w_empty) r_underflow <= 1'b1;
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign data_count   = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign wr_rst_busy  = 1'b0;
  assign rd_rst_busy  = 1'b0;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a standard-mode and an FWFT instance, both 4 deep,
// exercised with a vector table plus directed multi-cycle sequences.
module tb_fifo_sync_flags;

  localparam int DW = 12;
  localparam int AW = 2;
  localparam int AF = 3;
  localparam int AE = 1;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dv;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] din = '0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic dv, full, empty, af, ae, ovf, udf, wrb, rdb;
  logic [AW:0] cnt;

  logic [DW-1:0] f_din = '0;
  logic f_wr = 1'b0, f_rd = 1'b0;
  logic [DW-1:0] f_dout;
  logic f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_wrb, f_rdb;
  logic [AW:0] f_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DW(DW), .AW(AW), .FWFT(0), .AF_LVL(AF), .AE_LVL(AE)) u_dut (
    .clk(clk), .fifo_rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_valid(dv), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .data_count(cnt),
    .overflow(ovf), .underflow(udf), .wr_rst_busy(wrb), .rd_rst_busy(rdb)
  );

  fifo_sync_flags #(.DW(DW), .AW(AW), .FWFT(1), .AF_LVL(AF), .AE_LVL(AE)) u_fwft (
    .clk(clk), .fifo_rst_n(rst_n), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .wr_rst_busy(f_wrb), .rd_rst_busy(f_rdb)
  );

  initial begin
    if (!(AE >= 0 && AE < AF && AF <= 2**AW)) begin
      $display("FAIL params: AE_LVL=%0d AF_LVL=%0d unsupported", AE, AF);
      $fatal(1, "illegal level parameters");
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".dout"},  32'(dout),  32'(v.dout));
    check({tag, ".dv"},    32'(dv),    32'(v.dv));
    check({tag, ".full"},  32'(full),  32'(v.full));
    check({tag, ".empty"}, 32'(empty), 32'(v.empty));
    check({tag, ".af"},    32'(af),    32'(v.af));
    check({tag, ".ae"},    32'(ae),    32'(v.ae));
    check({tag, ".cnt"},   32'(cnt),   32'(v.cnt));
    check({tag, ".ovf"},   32'(ovf),   32'(v.ovf));
    check({tag, ".udf"},   32'(udf),   32'(v.udf));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".dout"},  32'(dout),  32'h0);
    check({tag, ".dv"},    32'(dv),    32'h0);
    check({tag, ".empty"}, 32'(empty), 32'h1);
    check({tag, ".ae"},    32'(ae),    32'h1);
    check({tag, ".full"},  32'(full),  32'h0);
    check({tag, ".cnt"},   32'(cnt),   32'h0);
    check({tag, ".ovf"},   32'(ovf),   32'h0);
    check({tag, ".udf"},   32'(udf),   32'h0);
    check({tag, ".busy"},  32'({wrb, rdb}), 32'h0);
    check({tag, ".f_empty"}, 32'(f_empty), 32'h1);
    check({tag, ".f_dv"},    32'(f_dv),    32'h0);
    check({tag, ".f_cnt"},   32'(f_cnt),   32'h0);
    check({tag, ".f_dout"},  32'(f_dout),  32'h0);
  endtask

  task automatic reset_quiet();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl [11];

  initial begin
    // wr rd din | dout dv full empty af ae cnt ovf udf
    tbl[0]  = '{1'b1, 1'b0, 12'h001, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 12'h002, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 12'h003, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 12'h004, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h005, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 12'h000, 12'h001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 12'h000, 12'h002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 12'h000, 12'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12'h000, 12'h004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 12'h000, 12'h004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 12'h004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset: dirty every state bit, then drop reset between edges.
    wr_en = 1'b1; rd_en = 1'b1; din = 12'h3A5;
    step();
    check("pre_reset.udf", 32'(udf), 32'h1);
    wr_en = 1'b0;
    step();
    check("pre_reset.dout", 32'(dout), 32'h3A5);
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full, overflow, drain, underflow.
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].wr; rd_en = tbl[i].rd; din = tbl[i].din;
      step();
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Streaming at constant occupancy across several pointer wraps.
    reset_quiet();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = (i >= 2); din = 12'(16 + i);
      step();
      if (i >= 2) begin
        check($sformatf("wrap%0d.dout", i), 32'(dout), 32'(16 + i - 2));
        check($sformatf("wrap%0d.dv", i),   32'(dv),   32'h1);
        check($sformatf("wrap%0d.cnt", i),  32'(cnt),  32'h2);
      end
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("wrap_tail%0d.dout", k), 32'(dout), 32'(12'h022 + k));
    end
    rd_en = 1'b0;
    step();
    check("wrap_end.empty", 32'(empty), 32'h1);

    // Full with simultaneous write and read.
    reset_quiet();
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 12'(12'h0A0 + i);
      step();
    end
    check("full.full", 32'(full), 32'h1);
    rd_en = 1'b1; din = 12'h0FF;
    step();
    check("fullrw.dout", 32'(dout), 32'h0A0);
    check("fullrw.dv",   32'(dv),   32'h1);
    check("fullrw.ovf",  32'(ovf),  32'h1);
    check("fullrw.cnt",  32'(cnt),  32'h3);
    check("fullrw.full", 32'(full), 32'h0);
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fullrw_drain%0d.dout", k), 32'(dout), 32'(12'h0A1 + k));
    end
    rd_en = 1'b0;
    check("fullrw_drain.empty", 32'(empty), 32'h1);
    check("fullrw_drain.cnt",   32'(cnt),   32'h0);

    // FWFT: two-edge latency into an empty FIFO, pop, underflow, fill and drain.
    reset_quiet();
    f_wr = 1'b1; f_din = 12'h0AB;
    step();
    f_wr = 1'b0;
    check("fw_n.dv",    32'(f_dv),    32'h0);
    check("fw_n.empty", 32'(f_empty), 32'h1);
    check("fw_n.cnt",   32'(f_cnt),   32'h1);
    step();
    check("fw_n1.dout",  32'(f_dout),  32'h0AB);
    check("fw_n1.dv",    32'(f_dv),    32'h1);
    check("fw_n1.empty", 32'(f_empty), 32'h0);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fw_pop.dv",    32'(f_dv),    32'h0);
    check("fw_pop.empty", 32'(f_empty), 32'h1);
    check("fw_pop.cnt",   32'(f_cnt),   32'h0);
    check("fw_pop.dout",  32'(f_dout),  32'h0AB);
    check("fw_pop.udf",   32'(f_udf),   32'h0);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fw_udf.udf", 32'(f_udf), 32'h1);
    f_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_din = 12'(12'h0C0 + i);
      step();
    end
    check("fw_full.full", 32'(f_full), 32'h1);
    check("fw_full.cnt",  32'(f_cnt),  32'h4);
    check("fw_full.dout", 32'(f_dout), 32'h0C0);
    f_din = 12'h0DD;
    step();
    f_wr = 1'b0;
    check("fw_ovf.ovf", 32'(f_ovf), 32'h1);
    check("fw_ovf.cnt", 32'(f_cnt), 32'h4);
    f_rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fw_drain%0d.dout", k), 32'(f_dout), 32'(12'h0C1 + k));
      check($sformatf("fw_drain%0d.cnt", k),  32'(f_cnt),  32'(3 - k));
    end
    step();
    f_rd = 1'b0;
    check("fw_last.dv",    32'(f_dv),    32'h0);
    check("fw_last.empty", 32'(f_empty), 32'h1);
    check("fw_last.dout",  32'(f_dout),  32'h0C3);

    // Reset mid-stream with count 3 and overflow set; stale words must not reappear.
    reset_quiet();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 12'(12'h0E0 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("mid.cnt", 32'(cnt), 32'h3);
    check("mid.ovf", 32'(ovf), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_en = 1'b1; din = 12'h055;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post.dout", 32'(dout), 32'h055);
    check("post.dv",   32'(dv),   32'h1);
    check("post.cnt",  32'(cnt),  32'h0);
    step();
    check("post_idle.dv",    32'(dv),    32'h0);
    check("post_idle.empty", 32'(empty), 32'h1);
    check("post_idle.dout",  32'(dout),  32'h055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
